// File: rtl/spi_pkg.sv
// spi_pkg: constants and types shared by the SPI master and responder blocks.
package spi_pkg;
    localparam int SPI_DATA_W = 16;
    localparam int SPI_CNT_W  = $clog2(SPI_DATA_W) + 1;
    typedef enum logic {IDLE, RECV} spi_rx_state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: optional input synchroniser plus sclk rising-edge detector for SPI responders.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_cs_l,
    input  logic spi_sclk,
    input  logic spi_data,
    output logic cs_l_o,
    output logic data_o,
    output logic sclk_rise_o
);
    logic sclk_c;
    logic sclk_q;
    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign cs_l_o = spi_cs_l;
            assign data_o = spi_data;
            assign sclk_c = spi_sclk;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] cs_q, sclk_s_q, data_q;
            // cs chain resets high so a reset release never looks like a select
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cs_q     <= '1;
                    sclk_s_q <= '0;
                    data_q   <= '0;
                end else begin
                    cs_q     <= (cs_q << 1) | SYNC_STAGES'(spi_cs_l);
                    sclk_s_q <= (sclk_s_q << 1) | SYNC_STAGES'(spi_sclk);
                    data_q   <= (data_q << 1) | SYNC_STAGES'(spi_data);
                end
            end
            assign cs_l_o = cs_q[SYNC_STAGES-1];
            assign data_o = data_q[SYNC_STAGES-1];
            assign sclk_c = sclk_s_q[SYNC_STAGES-1];
        end
    endgenerate
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sclk_q <= 1'b0;
        else        sclk_q <= sclk_c;
    end
    assign sclk_rise_o = sclk_c & ~sclk_q;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: deserialises MSB-first SPI words into a parallel bus with valid and frame-error strobes.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      spi_cs_l,
    input  logic                      spi_sclk,
    input  logic                      spi_data,
    output logic [DATA_W-1:0]         dataout,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic                      busy,
    output logic [$clog2(DATA_W):0]   bit_cnt
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    spi_rx_state_t state_q, state_d;
    logic cs_l, sdata, sclk_rise, shift, active;
    logic [DATA_W-1:0] shreg_q, shreg_d, dout_q, dout_d, shifted;
    logic [CW-1:0] cnt_q, cnt_d;
    logic valid_q, valid_d, ferr_q, ferr_d;
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .reset       (reset),
        .spi_cs_l    (spi_cs_l),
        .spi_sclk    (spi_sclk),
        .spi_data    (spi_data),
        .cs_l_o      (cs_l),
        .data_o      (sdata),
        .sclk_rise_o (sclk_rise)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // chip select alone decides the state from either side
    always_comb begin
        state_d = cs_l ? IDLE : RECV;
    end
    // a cs release beats a coincident sclk edge, so the count seen is pre-edge
    always_comb begin
        active  = (state_q == RECV) && !cs_l;
        shift   = active && sclk_rise;
        shifted = {shreg_q[DATA_W-2:0], sdata};
        cnt_d   = !active ? '0 : shift ? ((cnt_q == LAST) ? '0 : cnt_q + CW'(1)) : cnt_q;
        shreg_d = !active ? '0 : shift ? shifted : shreg_q;
        valid_d = shift && (cnt_q == LAST);
        dout_d  = valid_d ? shifted : dout_q;
        ferr_d  = (state_q == RECV) && cs_l && (cnt_q != '0);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
    assign dataout    = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q == RECV);
    assign bit_cnt    = cnt_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed plus randomized checks of the SPI receiver at both synchroniser depths.
module tb_spi_slave_rx;
    logic clk = 1'b0, reset = 1'b0, cs_l = 1'b1, sclk = 1'b0, sdata = 1'b0;
    logic [15:0] dout0, dout2;
    logic v0, v2, fe0, fe2, b0, b2;
    logic [4:0] bc0, bc2;
    int tests = 0, fails = 0, cyc = 0, last_rise = 0;
    int ferr0 = 0, ferr2 = 0;
    logic both_seen = 1'b0;
    logic [15:0] cap0[$], cap2[$];
    int cc0[$], cc2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(0)) u0 (
        .clk(clk), .reset(reset), .spi_cs_l(cs_l), .spi_sclk(sclk), .spi_data(sdata),
        .dataout(dout0), .data_valid(v0), .frame_err(fe0), .busy(b0), .bit_cnt(bc0));
    spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(2)) u2 (
        .clk(clk), .reset(reset), .spi_cs_l(cs_l), .spi_sclk(sclk), .spi_data(sdata),
        .dataout(dout2), .data_valid(v2), .frame_err(fe2), .busy(b2), .bit_cnt(bc2));

    always @(negedge clk) begin
        if (v0) begin cap0.push_back(dout0); cc0.push_back(cyc); end
        if (v2) begin cap2.push_back(dout2); cc2.push_back(cyc); end
        if (fe0) ferr0++;
        if (fe2) ferr2++;
        if ((v0 && fe0) || (v2 && fe2)) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b, input int half);
        sdata = b;
        sclk  = 1'b0;
        tick(half);
        sclk      = 1'b1;
        last_rise = cyc;
        tick(half);
    endtask

    task automatic frame(input logic [63:0] bits, input int n, input int half);
        cs_l = 1'b0;
        tick(1);
        chk("busy_rise", b0, 1);
        tick(1);
        for (int i = 0; i < n; i++) bit_out(bits[n-1-i], half);
        sclk = 1'b0;
        tick(half);
        cs_l = 1'b1;
        tick(1);
        chk("busy_fall", b0, 0);
        tick(3);
    endtask

    initial begin
        int s0, s2, f0, f2, n, half, nw;
        logic [63:0] bits;
        logic [15:0] exp_dout, w;

        tick(3);
        chk("reset_u0", {dout0, v0, fe0, b0, bc0}, 0);
        chk("reset_u2", {dout2, v2, fe2, b2, bc2}, 0);
        reset = 1'b1;
        tick(2);

        f0 = ferr0;
        cs_l = 1'b0;
        tick(2);
        for (int i = 0; i < 8; i++) bit_out(1'b1, 1);
        chk("midword_cnt", bc0, 8);
        #2 reset = 1'b0;
        #1 chk("midword_reset", {dout0, v0, fe0, b0, bc0}, 0);
        cs_l = 1'b1;
        sclk = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("midword_no_ferr", ferr0 - f0, 0);
        frame(64'h1234, 16, 1);
        chk("after_reset_word", dout0, 16'h1234);

        s0 = cap0.size();
        frame(64'h0412, 16, 1);
        chk("single_count", cap0.size() - s0, 1);
        chk("single_value", cap0[$], 16'h0412);
        chk("single_cnt0", bc0, 0);

        s0 = cap0.size();
        f0 = ferr0;
        frame(64'h4839, 16, 1);
        frame(64'hABEB, 16, 1);
        chk("seq_count", cap0.size() - s0, 2);
        chk("seq_first", cap0[s0], 16'h4839);
        chk("seq_second", cap0[s0+1], 16'hABEB);
        chk("seq_no_ferr", ferr0 - f0, 0);

        s0 = cap0.size();
        frame(64'hA5A5_5A5A, 32, 1);
        chk("b2b_count", cap0.size() - s0, 2);
        chk("b2b_first", cap0[s0], 16'hA5A5);
        chk("b2b_second", cap0[s0+1], 16'h5A5A);
        chk("b2b_spacing", cc0[s0+1] - cc0[s0], 32);

        s0 = cap0.size();
        f0 = ferr0;
        frame(64'h1FF, 9, 1);
        chk("trunc_ferr", ferr0 - f0, 1);
        chk("trunc_no_valid", cap0.size() - s0, 0);
        chk("trunc_hold", dout0, 16'h5A5A);
        chk("trunc_idle", {b0, bc0}, 0);

        s0 = cap0.size();
        f0 = ferr0;
        cs_l = 1'b0;
        tick(2);
        for (int i = 0; i < 15; i++) bit_out(1'b0, 1);
        sdata = 1'b1;
        sclk  = 1'b0;
        tick(1);
        sclk = 1'b1;
        cs_l = 1'b1;
        tick(1);
        sclk = 1'b0;
        tick(3);
        chk("collide_ferr", ferr0 - f0, 1);
        chk("collide_no_valid", cap0.size() - s0, 0);
        chk("collide_hold", dout0, 16'h5A5A);

        s0 = cap0.size();
        s2 = cap2.size();
        f2 = ferr2;
        frame(64'hC3C3, 16, 2);
        chk("async_u2_count", cap2.size() - s2, 1);
        chk("async_u2_value", dout2, 16'hC3C3);
        chk("async_u2_latency", cc2[$] - last_rise, 3);
        chk("async_u0_latency", cc0[$] - last_rise, 1);
        chk("async_u2_no_ferr", ferr2 - f2, 0);
        chk("async_u0_value", cap0.size() - s0 == 1 ? cap0[$] : 16'h0, 16'hC3C3);

        exp_dout = 16'hC3C3;
        for (int t = 0; t < 8; t++) begin
            n    = $urandom_range(1, 40);
            half = $urandom_range(1, 3);
            bits = {$urandom(), $urandom()};
            nw   = n / 16;
            s0   = cap0.size();
            f0   = ferr0;
            frame(bits, n, half);
            chk("rand_count", cap0.size() - s0, nw);
            for (int k = 0; k < nw && k < cap0.size() - s0; k++) begin
                w = 16'(bits >> (n - 16 * (k + 1)));
                chk("rand_word", cap0[s0+k], w);
                exp_dout = w;
            end
            chk("rand_ferr", ferr0 - f0, (n % 16 != 0) ? 1 : 0);
            chk("rand_dout", dout0, exp_dout);
        end

        chk("valid_ferr_exclusive", both_seen, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
